// File: rtl/mips_pkg.sv
// Shared types and constants for the 16-bit MIPS writeback stage.
// The opcode helpers define which instructions write the register file and from which field.
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_SLTI  = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [2:0]        opcode;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
    } memwb_t;

    function automatic logic op_writes_reg(input logic [2:0] opcode);
        logic result;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SLTI: result = 1'b1;
            default:                           result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic op_dest_is_rt(input logic [2:0] opcode);
        logic result;
        case (opcode)
            OP_ADDI, OP_LW, OP_SLTI: result = 1'b1;
            default:                 result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB bus plus the register-file write port and bypass flags seen by decode.
// master drives MEM fields and decode read addresses; slave is the writeback stage.
interface writeback_stage_if;
    import mips_pkg::*;

    logic              mem_valid;
    logic [2:0]        mem_opcode;
    logic [REG_AW-1:0] mem_rt;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic              wb_stall;
    logic              wb_flush;
    logic [REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0] dec_rt;
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              fwd_a;
    logic              fwd_b;

    modport master (
        output mem_valid, mem_opcode, mem_rt, mem_rd, mem_alu_result, mem_read_data,
        output wb_stall, wb_flush, dec_rs, dec_rt,
        input  reg_write, write_reg, write_data, fwd_a, fwd_b
    );

    modport slave (
        input  mem_valid, mem_opcode, mem_rt, mem_rd, mem_alu_result, mem_read_data,
        input  wb_stall, wb_flush, dec_rs, dec_rt,
        output reg_write, write_reg, write_data, fwd_a, fwd_b
    );

endinterface

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: flush has priority over stall, asynchronous active-high reset.
module wb_pipe_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  memwb_t d,
    output memwb_t q
);

    memwb_t q_r;

    // Pipeline register update: flush clears, stall holds, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (flush) begin
            q_r <= '0;
        end else if (stall) begin
            q_r <= q_r;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, write-port select with R0 suppression, same-cycle bypass flags.
// Optional WB_RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module writeback_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]       retire_count,
`endif
    writeback_stage_if.slave  wb
);

    memwb_t            d_s;
    memwb_t            q_s;
    logic [REG_AW-1:0] dest_s;
    logic [DATA_W-1:0] data_s;
    logic              reg_write_s;

    assign d_s.valid      = wb.mem_valid;
    assign d_s.opcode     = wb.mem_opcode;
    assign d_s.rt         = wb.mem_rt;
    assign d_s.rd         = wb.mem_rd;
    assign d_s.alu_result = wb.mem_alu_result;
    assign d_s.read_data  = wb.mem_read_data;

    wb_pipe_reg u_pipe (
        .clk   (clk),
        .rst   (rst),
        .stall (wb.wb_stall),
        .flush (wb.wb_flush),
        .d     (d_s),
        .q     (q_s)
    );

    // Destination/data select; outputs forced to zero whenever no write is pending
    always_comb begin
        dest_s      = op_dest_is_rt(q_s.opcode) ? q_s.rt : q_s.rd;
        data_s      = (q_s.opcode == OP_LW) ? q_s.read_data : q_s.alu_result;
        reg_write_s = q_s.valid & op_writes_reg(q_s.opcode) & (dest_s != {REG_AW{1'b0}});
        if (reg_write_s) begin
            wb.reg_write  = 1'b1;
            wb.write_reg  = dest_s;
            wb.write_data = data_s;
        end else begin
            wb.reg_write  = 1'b0;
            wb.write_reg  = {REG_AW{1'b0}};
            wb.write_data = {DATA_W{1'b0}};
        end
    end

    // Bypass flags let decode see the value the register file only commits at the next edge
    always_comb begin
        wb.fwd_a = reg_write_s & (wb.dec_rs == dest_s);
        wb.fwd_b = reg_write_s & (wb.dec_rt == dest_s);
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count_r;
    logic        retire_s;

    // An instruction retires when it leaves the register, including by flush
    assign retire_s = q_s.valid & (~wb.wb_stall | wb.wb_flush);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_r <= 32'd0;
        end else if (retire_s) begin
            retire_count_r <= retire_count_r + 32'd1;
        end else begin
            retire_count_r <= retire_count_r;
        end
    end

    assign retire_count = retire_count_r;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table with an expected-result queue,
// plus hand sequences for asynchronous reset and (with WB_RETIRE_COUNT_EN) the retire counter.
module tb_writeback_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if wb ();
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    writeback_stage dut (
        .clk          (clk),
        .rst          (rst),
`ifdef WB_RETIRE_COUNT_EN
        .retire_count (retire_count),
`endif
        .wb           (wb)
    );

    typedef struct {
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        fa;
        logic        fb;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] alu;
        logic [15:0] rdata;
        logic        stall;
        logic        flush;
        logic [2:0]  drs;
        logic [2:0]  drt;
        exp_t        e;
    } vec_t;

    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [2:0] rt,
                                input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] rdata,
                                input logic st, input logic fl, input logic [2:0] drs, input logic [2:0] drt,
                                input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                                input logic fa, input logic fb);
        vec_t t;
        t.valid = v;  t.op = op;   t.rt = rt;   t.rd = rd;   t.alu = alu; t.rdata = rdata;
        t.stall = st; t.flush = fl; t.drs = drs; t.drt = drt;
        t.e.rw = rw;  t.e.wr = wr; t.e.wd = wd; t.e.fa = fa; t.e.fb = fb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        wb.mem_valid      = t.valid;
        wb.mem_opcode     = t.op;
        wb.mem_rt         = t.rt;
        wb.mem_rd         = t.rd;
        wb.mem_alu_result = t.alu;
        wb.mem_read_data  = t.rdata;
        wb.wb_stall       = t.stall;
        wb.wb_flush       = t.flush;
        wb.dec_rs         = t.drs;
        wb.dec_rt         = t.drt;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".reg_write"},  {31'd0, wb.reg_write}, {31'd0, e.rw});
        check({tag, ".write_reg"},  {29'd0, wb.write_reg}, {29'd0, e.wr});
        check({tag, ".write_data"}, {16'd0, wb.write_data}, {16'd0, e.wd});
        check({tag, ".fwd_a"},      {31'd0, wb.fwd_a},     {31'd0, e.fa});
        check({tag, ".fwd_b"},      {31'd0, wb.fwd_b},     {31'd0, e.fb});
    endtask

    function automatic vec_t idle();
        return mk(1'b0, OP_NOP, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0,
                  1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    endfunction

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        vec_t t;
        e0 = idle().e;

        // Table: each row is driven before an edge; expectation is the state after that edge
        //          v     op        rt    rd    alu       rdata     st    fl    drs   drt   rw    wr    wd        fa    fb
        vecs.push_back(mk(1'b1, OP_RTYPE, 3'd1, 3'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd3, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, OP_LW,    3'd5, 3'd2, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 3'd1, 3'd5, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, OP_SW,    3'd2, 3'd4, 16'h0010, 16'h9999, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_ADDI,  3'd0, 3'd5, 16'h0055, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_ADDI,  3'd4, 3'd6, 16'h0007, 16'h0000, 1'b0, 1'b0, 3'd4, 3'd4, 1'b1, 3'd4, 16'h0007, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, OP_RTYPE, 3'd1, 3'd7, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 3'd4, 16'h0007, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, OP_LW,    3'd1, 3'd2, 16'h2222, 16'h3333, 1'b1, 1'b0, 3'd7, 3'd4, 1'b1, 3'd4, 16'h0007, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, OP_RTYPE, 3'd2, 3'd3, 16'h4444, 16'h0000, 1'b1, 1'b0, 3'd4, 3'd0, 1'b1, 3'd4, 16'h0007, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, OP_RTYPE, 3'd1, 3'd2, 16'hAAAA, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd4, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_RTYPE, 3'd3, 3'd6, 16'h0C0C, 16'h0000, 1'b0, 1'b0, 3'd6, 3'd1, 1'b1, 3'd6, 16'h0C0C, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, OP_RTYPE, 3'd3, 3'd0, 16'h1111, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_SLTI,  3'd7, 3'd1, 16'h0001, 16'h5A5A, 1'b0, 1'b0, 3'd1, 3'd7, 1'b1, 3'd7, 16'h0001, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, OP_RTYPE, 3'd1, 3'd3, 16'h7777, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_BEQ,   3'd3, 3'd3, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_J,     3'd2, 3'd2, 16'h00FF, 16'h0000, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_NOP,   3'd1, 3'd1, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_LW,    3'd7, 3'd1, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'd7, 3'd1, 1'b1, 3'd7, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, OP_ADDI,  3'd2, 3'd1, 16'h0099, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));

        // Reset state
        drive(idle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_outputs("reset", e0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            sb_q.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check($sformatf("vec%0d.scoreboard_empty", i), 32'd1, 32'd0);
            end else begin
                check_outputs($sformatf("vec%0d", i), sb_q.pop_front());
            end
        end

        // Asynchronous reset mid-cycle drops a loaded LW
        @(negedge clk);
        t = mk(1'b1, OP_LW, 3'd5, 3'd0, 16'h0040, 16'h1357, 1'b0, 1'b0, 3'd5, 3'd0,
               1'b1, 3'd5, 16'h1357, 1'b1, 1'b0);
        drive(t);
        @(posedge clk);
        #1 check_outputs("lw_before_reset", t.e);
        #2 rst = 1'b1;
        #1 check_outputs("async_reset", e0);
        @(negedge clk) drive(idle());
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check_outputs("after_reset_idle", e0);

`ifdef WB_RETIRE_COUNT_EN
        @(negedge clk) rst = 1'b1;
        #1 check("retire.reset", retire_count, 32'd0);
        @(negedge clk) rst = 1'b0;
        t = mk(1'b1, OP_ADDI, 3'd1, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0,
               1'b1, 3'd1, 16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(t);
            @(negedge clk);
        end
        drive(idle());
        @(negedge clk);
        check("retire.ten", retire_count, 32'd10);
        drive(t);
        @(negedge clk);
        t.stall = 1'b1;
        drive(t);
        @(negedge clk);
        check("retire.stall_hold", retire_count, 32'd10);
        t.flush = 1'b1;
        drive(t);
        @(negedge clk);
        check("retire.flush_counts", retire_count, 32'd11);
        drive(idle());
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
